// File: rtl/mem_pkg.sv
// Shared types, default parameters and address helper for the block memory.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } mem_state_t;

  localparam int MEM_BLOCK_BYTES  = 16;
  localparam int MEM_ADDR_W       = 28;
  localparam int MEM_DEPTH_BLOCKS = 16;
  localparam int MEM_LATENCY      = 5;

  // Byte k of block A lives at A*block_bytes + k in the flat byte array.
  function automatic int unsigned byte_index(input int unsigned block,
                                             input int unsigned offset,
                                             input int unsigned block_bytes);
    return block * block_bytes + offset;
  endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Down-counter that measures access latency; done is high while the count is zero.
module mem_latency_timer
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/param_block_memory.sv
// Block-granular main-memory model behind the data cache: read/write/busywait
// handshake with a fixed access latency, an ACK cycle and out-of-range errors.
module param_block_memory
  import mem_pkg::*;
#(
  parameter int BLOCK_BYTES  = MEM_BLOCK_BYTES,
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DEPTH_BLOCKS = MEM_DEPTH_BLOCKS,
  parameter int LATENCY      = MEM_LATENCY
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        address,
  input  logic [8*BLOCK_BYTES-1:0] writedata,
  output logic [8*BLOCK_BYTES-1:0] readdata,
  output logic                     busywait,
  output logic                     error
);

  localparam int IDX_W     = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam int ARR_BYTES = DEPTH_BLOCKS * BLOCK_BYTES;
  localparam int ARR_W     = $clog2(ARR_BYTES);

  logic [7:0] mem_array [ARR_BYTES];

  mem_state_t state, state_next;

  logic                     valid_req;
  logic                     accept;
  logic                     access;
  logic                     timer_done;
  logic                     lat_write;
  logic [ADDR_W-1:0]        lat_addr;
  logic [8*BLOCK_BYTES-1:0] lat_wdata;
  logic                     in_range;
  logic [IDX_W-1:0]         lat_idx;

  // Read and write together is an illegal request and is simply not seen.
  assign valid_req = read ^ write;
  assign in_range  = (lat_addr < ADDR_W'(DEPTH_BLOCKS));
  assign lat_idx   = lat_addr[IDX_W-1:0];

  function automatic logic [ARR_W-1:0] arr_addr(input logic [IDX_W-1:0] idx, input int k);
    return ARR_W'(byte_index(32'(idx), k, BLOCK_BYTES));
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busywait   = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    unique case (state)
      IDLE: begin
        // Held low while reset is asserted so an aborted requester sees no stall.
        if (valid_req && !reset) begin
          busywait   = 1'b1;
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (timer_done) begin
          access     = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mem_latency_timer #(
    .LATENCY(LATENCY)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .enable(state == BUSY),
    .done  (timer_done)
  );

  // NOTE: the byte array is cleared by reset too, so it must stay in flops rather than a RAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      readdata  <= '0;
      error     <= 1'b0;
      for (int i = 0; i < ARR_BYTES; i++) begin
        mem_array[i] <= 8'h00;
      end
    end else begin
      error <= 1'b0;
      if (accept) begin
        lat_write <= write;
        lat_addr  <= address;
        lat_wdata <= writedata;
      end
      if (access) begin
        if (!in_range) begin
          error <= 1'b1;
          if (!lat_write) begin
            readdata <= '0;
          end
        end else if (lat_write) begin
          for (int k = 0; k < BLOCK_BYTES; k++) begin
            mem_array[arr_addr(lat_idx, k)] <= lat_wdata[8*k +: 8];
          end
        end else begin
          for (int k = 0; k < BLOCK_BYTES; k++) begin
            readdata[8*k +: 8] <= mem_array[arr_addr(lat_idx, k)];
          end
        end
      end
    end
  end

endmodule
